// File: rtl/ov5640_init_sequencer.sv
// OV5640 init table walker: fetches {reg_addr, reg_data} entries from ROM
// and issues one SCCB write per entry, with power-up and soft-reset waits.
module ov5640_init_sequencer #(
  parameter int ADDR_WIDTH         = 8,
  parameter int TABLE_DEPTH        = 252,
  parameter int PWRUP_DELAY_CYCLES = 1_000_000,
  parameter int RESET_DELAY_CYCLES = 250_000,
  parameter int MAX_RETRY          = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_q,
  output logic                  wr_req,
  output logic [15:0]           wr_reg_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_done,
  input  logic                  wr_nack,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_error,
  output logic [ADDR_WIDTH-1:0] err_index
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_FETCH,
    S_LOAD,
    S_REQ,
    S_GAP,
    S_RST_WAIT,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(TABLE_DEPTH - 1);
  localparam logic [31:0] PWR_LAST = 32'(PWRUP_DELAY_CYCLES - 1);
  localparam logic [31:0] RST_LAST = 32'(RESET_DELAY_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]            retry_q, retry_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [15:0]           reg_addr_q, reg_addr_d;
  logic [7:0]            reg_data_q, reg_data_d;
  logic [ADDR_WIDTH-1:0] err_idx_q, err_idx_d;
  logic                  wr_req_q, wr_req_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  soft_reset_wr;

  assign soft_reset_wr = (reg_addr_q == 16'h3008) && reg_data_q[7];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    err_idx_d  = err_idx_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = (PWRUP_DELAY_CYCLES == 0) ? S_FETCH : S_PWR_WAIT;
          idx_d     = '0;
          retry_d   = '0;
          cnt_d     = '0;
          err_idx_d = '0;
        end
      end
      S_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        reg_addr_d = rom_q[23:8];
        reg_data_d = rom_q[7:0];
        state_d    = S_REQ;
      end
      S_REQ: begin
        if (wr_done) begin
          if (!wr_nack) begin
            if (soft_reset_wr && RESET_DELAY_CYCLES != 0) begin
              cnt_d   = '0;
              state_d = S_RST_WAIT;
            end else begin
              state_d = S_NEXT;
            end
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 8'd1;
            state_d = S_GAP;
          end else begin
            err_idx_d = idx_q;
            state_d   = S_ERROR;
          end
        end
      end
      // One idle cycle with wr_req low before re-requesting the same entry
      S_GAP: state_d = S_REQ;
      S_RST_WAIT: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs registered from the next state so they align with the state
  always_comb begin
    wr_req_d = (state_d == S_REQ);
    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE) &&
               (state_d != S_ERROR);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      err_idx_q  <= '0;
      wr_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      err_idx_q  <= err_idx_d;
      wr_req_q   <= wr_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rom_addr    = idx_q;
  assign wr_req      = wr_req_q;
  assign wr_reg_addr = reg_addr_q;
  assign wr_data     = reg_data_q;
  assign busy        = busy_q;
  assign init_done   = done_q;
  assign init_error  = error_q;
  assign err_index   = err_idx_q;

endmodule
